// File: rtl/bram_byte_packer_if.sv
// Byte-stream and BRAM port-A signal bundle for bram_byte_packer.
// master: upstream byte source / downstream reader side.
// slave:  the packer itself.
interface bram_byte_packer_if #(
  parameter int unsigned ADDR_WIDTH = 11
);

  // Byte stream from the producer
  logic [7:0]            DIN;
  logic                  DIN_VALID;
  logic                  DIN_READY;

  // Frame control
  logic                  ABORT;
  logic                  RELEASE;

  // BRAM port-A write side
  logic [7:0]            DIN_A;
  logic [ADDR_WIDTH-1:0] ADDR_A;
  logic                  W_A;
  logic                  EN_A;

  // Frame status
  logic                  FRAME_READY;
  logic                  FRAME_DONE;
  logic [ADDR_WIDTH-1:0] WORD_CNT;

  modport master (
    output DIN, DIN_VALID, ABORT, RELEASE,
    input  DIN_READY, DIN_A, ADDR_A, W_A, EN_A,
           FRAME_READY, FRAME_DONE, WORD_CNT
  );

  modport slave (
    input  DIN, DIN_VALID, ABORT, RELEASE,
    output DIN_READY, DIN_A, ADDR_A, W_A, EN_A,
           FRAME_READY, FRAME_DONE, WORD_CNT
  );

endinterface

// File: rtl/bram_byte_packer.sv
// Write-side controller that packs a byte stream into a quadrant-organised
// BRAM: byte k of word w lands at w + k*BASE_ADDRESS, so the read port sees
// {byte3, byte2, byte1, byte0} as one 32-bit word. One frame of WORDS words
// is filled, then held until the reader releases it.
module bram_byte_packer #(
  parameter int unsigned BASE_ADDRESS = 512,
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned WORDS        = 512
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  bram_byte_packer_if.slave    bus
);

  localparam int unsigned AW = ADDR_WIDTH;

  localparam logic [AW-1:0] LP_LAST_WORD = AW'(WORDS - 1);
  localparam logic [AW-1:0] LP_WORDS     = AW'(WORDS);
  localparam logic [AW-1:0] LP_STRIDE    = AW'(BASE_ADDRESS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  // Registered state
  state_t        r_state;
  logic [1:0]    r_lane;
  logic [AW-1:0] r_word;
  logic [AW-1:0] r_word_cnt;
  logic          r_din_ready;
  logic [7:0]    r_din_a;
  logic [AW-1:0] r_addr_a;
  logic          r_w_a;
  logic          r_frame_ready;
  logic          r_frame_done;

  // Next-state values
  state_t        w_nxt_state;
  logic [1:0]    w_nxt_lane;
  logic [AW-1:0] w_nxt_word;
  logic [AW-1:0] w_nxt_word_cnt;
  logic          w_nxt_din_ready;
  logic [7:0]    w_nxt_din_a;
  logic [AW-1:0] w_nxt_addr_a;
  logic          w_nxt_w_a;
  logic          w_nxt_frame_ready;
  logic          w_nxt_frame_done;

  logic          w_accept;
  logic          w_last_byte;
  logic [AW-1:0] w_byte_addr;

  // A byte transfers on valid&&ready, but an abort in the same cycle wins
  assign w_accept    = bus.DIN_VALID && r_din_ready && !bus.ABORT
                       && (r_state == ST_FILL);
  assign w_last_byte = (r_lane == 2'd3) && (r_word == LP_LAST_WORD);
  assign w_byte_addr = AW'(r_word + AW'(AW'(r_lane) * LP_STRIDE));

  // Next-state and output logic
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_lane        = r_lane;
    w_nxt_word        = r_word;
    w_nxt_word_cnt    = r_word_cnt;
    w_nxt_din_a       = r_din_a;
    w_nxt_addr_a      = r_addr_a;
    w_nxt_w_a         = 1'b0;
    w_nxt_frame_ready = r_frame_ready;
    w_nxt_frame_done  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_nxt_state = ST_FILL;
      end

      ST_FILL: begin
        if (bus.ABORT) begin
          w_nxt_lane        = 2'd0;
          w_nxt_word        = '0;
          w_nxt_word_cnt    = '0;
          w_nxt_frame_ready = 1'b0;
        end else if (w_accept) begin
          w_nxt_din_a  = bus.DIN;
          w_nxt_addr_a = w_byte_addr;
          w_nxt_w_a    = 1'b1;
          w_nxt_lane   = 2'(r_lane + 2'd1);
          if (r_lane == 2'd3) begin
            if (w_last_byte) begin
              w_nxt_word        = '0;
              w_nxt_word_cnt    = LP_WORDS;
              w_nxt_state       = ST_FULL;
              w_nxt_frame_done  = 1'b1;
              w_nxt_frame_ready = 1'b1;
            end else begin
              w_nxt_word     = AW'(r_word + AW'(1));
              w_nxt_word_cnt = AW'(r_word_cnt + AW'(1));
            end
          end
        end
      end

      ST_FULL: begin
        if (bus.ABORT) begin
          w_nxt_lane        = 2'd0;
          w_nxt_word        = '0;
          w_nxt_word_cnt    = '0;
          w_nxt_frame_ready = 1'b0;
          w_nxt_state       = ST_FILL;
        end else if (bus.RELEASE) begin
          w_nxt_word_cnt    = '0;
          w_nxt_frame_ready = 1'b0;
          w_nxt_state       = ST_FILL;
        end
      end

      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase

    // Ready drops on the edge that takes the last byte, so FULL never accepts
    w_nxt_din_ready = (w_nxt_state == ST_FILL) && !bus.ABORT;
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= ST_IDLE;
      r_lane        <= 2'd0;
      r_word        <= '0;
      r_word_cnt    <= '0;
      r_din_ready   <= 1'b0;
      r_din_a       <= 8'd0;
      r_addr_a      <= '0;
      r_w_a         <= 1'b0;
      r_frame_ready <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_lane        <= w_nxt_lane;
      r_word        <= w_nxt_word;
      r_word_cnt    <= w_nxt_word_cnt;
      r_din_ready   <= w_nxt_din_ready;
      r_din_a       <= w_nxt_din_a;
      r_addr_a      <= w_nxt_addr_a;
      r_w_a         <= w_nxt_w_a;
      r_frame_ready <= w_nxt_frame_ready;
      r_frame_done  <= w_nxt_frame_done;
    end
  end

  assign bus.DIN_READY   = r_din_ready;
  assign bus.DIN_A       = r_din_a;
  assign bus.ADDR_A      = r_addr_a;
  assign bus.W_A         = r_w_a;
  assign bus.EN_A        = r_w_a;
  assign bus.FRAME_READY = r_frame_ready;
  assign bus.FRAME_DONE  = r_frame_done;
  assign bus.WORD_CNT    = r_word_cnt;

endmodule

// File: tb/tb_bram_byte_packer.sv
// Self-checking bench for bram_byte_packer in a small configuration
// (4-byte quadrant stride, 4 words per frame), with a frame-level model.
module tb_bram_byte_packer;

  localparam int BASE  = 4;
  localparam int AW    = 4;
  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic rst_n;

  bram_byte_packer_if #(.ADDR_WIDTH(AW)) bus();

  bram_byte_packer #(
    .BASE_ADDRESS(BASE),
    .ADDR_WIDTH  (AW),
    .WORDS       (WORDS)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM fed by the DUT write port
  logic [7:0] bram [0:15];
  always @(posedge clk) begin
    if (bus.EN_A && bus.W_A) bram[bus.ADDR_A] <= bus.DIN_A;
  end

  function automatic logic [31:0] rd_word(input int w);
    rd_word = {bram[w + 3*BASE], bram[w + 2*BASE], bram[w + BASE], bram[w]};
  endfunction

  int checks = 0;
  int errors = 0;

  // Frame-level model: phase 0 idle, 1 filling, 2 holding a full frame
  int          m_phase;
  int          m_n;
  logic        e_ready, e_w, e_done, e_fr;
  logic [7:0]  e_din;
  logic [3:0]  e_addr, e_cnt;

  task automatic model_reset();
    m_phase = 0; m_n = 0;
    e_ready = 0; e_w = 0; e_done = 0; e_fr = 0;
    e_din = 8'h00; e_addr = 4'h0; e_cnt = 4'h0;
  endtask

  // One clock with given inputs; updates model expectations after the edge
  task automatic cycle(input logic v, input logic [7:0] d, input logic ab, input logic rel);
    logic acc;
    bus.DIN_VALID = v; bus.DIN = d; bus.ABORT = ab; bus.RELEASE = rel;
    acc = v && e_ready && !ab;
    @(posedge clk); #1;
    e_w = 0; e_done = 0;
    case (m_phase)
      0: m_phase = 1;
      1: begin
        if (ab) m_n = 0;
        else if (acc) begin
          e_w = 1; e_din = d;
          e_addr = 4'((m_n / 4) + (m_n % 4) * BASE);
          m_n++;
          if (m_n == 4 * WORDS) begin m_phase = 2; m_n = 0; e_done = 1; end
        end
      end
      default: begin
        if (ab || rel) begin m_phase = 1; m_n = 0; end
      end
    endcase
    e_fr    = (m_phase == 2);
    e_cnt   = (m_phase == 2) ? 4'(WORDS) : 4'(m_n / 4);
    e_ready = (m_phase == 1) && !ab;
    bus.DIN_VALID = 0; bus.ABORT = 0; bus.RELEASE = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    bus.DIN_VALID = 0; bus.DIN = 0; bus.ABORT = 0; bus.RELEASE = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.DIN_READY, bus.DIN_A, bus.ADDR_A, bus.W_A, bus.EN_A, bus.FRAME_READY,
         bus.FRAME_DONE, bus.WORD_CNT} !== 21'h0) begin
      errors++;
      $display("FAIL reset_values got %h exp 0", {bus.DIN_READY, bus.DIN_A, bus.ADDR_A,
               bus.W_A, bus.EN_A, bus.FRAME_READY, bus.FRAME_DONE, bus.WORD_CNT});
    end
    rst_n = 1;
    cycle(0, 8'h00, 0, 0);
    checks++;
    if (bus.DIN_READY !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", bus.DIN_READY); end
  endtask

  task automatic test_fill();
    int dones = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1, 8'(8'h10 + i), 0, 0);
      if (bus.FRAME_DONE) dones++;
      checks++;
      if (bus.W_A !== e_w || bus.EN_A !== e_w) begin errors++; $display("FAIL fill_wa[%0d] got %b/%b exp %b", i, bus.W_A, bus.EN_A, e_w); end
      checks++;
      if (bus.ADDR_A !== e_addr || bus.DIN_A !== e_din) begin
        errors++; $display("FAIL fill_write[%0d] got %h@%h exp %h@%h", i, bus.DIN_A, bus.ADDR_A, e_din, e_addr);
      end
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL fill_done_count got %0d exp 1", dones); end
    checks++;
    if (bus.FRAME_READY !== 1'b1 || bus.WORD_CNT !== 4'd4) begin
      errors++; $display("FAIL fill_status got fr=%b cnt=%0d exp fr=1 cnt=4", bus.FRAME_READY, bus.WORD_CNT);
    end
    checks++;
    if (bus.DIN_READY !== 1'b0) begin errors++; $display("FAIL fill_ready_drop got %b exp 0", bus.DIN_READY); end
    // One more edge commits the final write into the BRAM
    cycle(1, 8'h20, 0, 0);
    checks++;
    if (rd_word(0) !== 32'h13121110) begin errors++; $display("FAIL bram_word0 got %h exp 13121110", rd_word(0)); end
    checks++;
    if (rd_word(3) !== 32'h1F1E1D1C) begin errors++; $display("FAIL bram_word3 got %h exp 1f1e1d1c", rd_word(3)); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 8'(8'h30 + i), 0, 0);
      checks++;
      if (bus.DIN_READY !== 1'b0 || bus.W_A !== 1'b0 || bus.FRAME_READY !== 1'b1) begin
        errors++; $display("FAIL full_hold[%0d] got rdy=%b wa=%b fr=%b exp 0 0 1", i, bus.DIN_READY, bus.W_A, bus.FRAME_READY);
      end
    end
    cycle(1, 8'h3F, 0, 1);
    checks++;
    if (bus.DIN_READY !== 1'b1 || bus.WORD_CNT !== 4'd0 || bus.FRAME_READY !== 1'b0 || bus.W_A !== 1'b0) begin
      errors++; $display("FAIL release got rdy=%b cnt=%0d fr=%b wa=%b exp 1 0 0 0", bus.DIN_READY, bus.WORD_CNT, bus.FRAME_READY, bus.W_A);
    end
    cycle(1, 8'hA5, 0, 0);
    checks++;
    if (bus.W_A !== 1'b1 || bus.ADDR_A !== 4'd0 || bus.DIN_A !== 8'hA5) begin
      errors++; $display("FAIL post_release_write got wa=%b %h@%h exp 1 a5@0", bus.W_A, bus.DIN_A, bus.ADDR_A);
    end
    cycle(0, 8'h00, 1, 0);
  endtask

  task automatic test_gapped();
    logic done_seen = 0;
    int   dones = 0;
    for (int i = 0; i < 300 && !done_seen; i++) begin
      cycle(($urandom_range(0, 2) != 0), 8'($urandom), 0, 0);
      if (bus.FRAME_DONE) dones++;
      done_seen = e_done;
      checks++;
      if (bus.DIN_READY !== e_ready || bus.W_A !== e_w) begin
        errors++; $display("FAIL gap_hs[%0d] got rdy=%b wa=%b exp %b %b", i, bus.DIN_READY, bus.W_A, e_ready, e_w);
      end
      checks++;
      if (bus.ADDR_A !== e_addr || bus.DIN_A !== e_din) begin
        errors++; $display("FAIL gap_write[%0d] got %h@%h exp %h@%h", i, bus.DIN_A, bus.ADDR_A, e_din, e_addr);
      end
      checks++;
      if (bus.WORD_CNT !== e_cnt) begin errors++; $display("FAIL gap_cnt[%0d] got %0d exp %0d", i, bus.WORD_CNT, e_cnt); end
    end
    checks++;
    if (!done_seen || dones !== 1) begin errors++; $display("FAIL gap_frame got done=%0d exp 1 (timeout=%b)", dones, !done_seen); end
    cycle(0, 8'h00, 0, 1);
  endtask

  task automatic test_abort();
    logic done_seen = 0;
    for (int i = 0; i < 40 && m_n < 6; i++) cycle(1, 8'($urandom), 0, 0);
    checks++;
    if (bus.WORD_CNT !== 4'd1) begin errors++; $display("FAIL pre_abort_cnt got %0d exp 1", bus.WORD_CNT); end
    cycle(1, 8'hEE, 1, 0);
    checks++;
    if (bus.WORD_CNT !== 4'd0 || bus.W_A !== 1'b0 || bus.DIN_READY !== 1'b0) begin
      errors++; $display("FAIL abort got cnt=%0d wa=%b rdy=%b exp 0 0 0", bus.WORD_CNT, bus.W_A, bus.DIN_READY);
    end
    for (int i = 0; i < 40 && !done_seen; i++) begin
      cycle(1, 8'(8'h40 + i), 0, 0);
      done_seen = e_done;
      if (e_w && m_n == 1) begin
        checks++;
        if (bus.ADDR_A !== 4'd0 || bus.DIN_A !== e_din) begin
          errors++; $display("FAIL abort_first_write got %h@%h exp %h@0", bus.DIN_A, bus.ADDR_A, e_din);
        end
      end
      checks++;
      if (bus.W_A !== e_w || bus.ADDR_A !== e_addr) begin
        errors++; $display("FAIL abort_fill[%0d] got wa=%b a=%h exp %b %h", i, bus.W_A, bus.ADDR_A, e_w, e_addr);
      end
    end
    checks++;
    if (!done_seen || bus.FRAME_DONE !== 1'b1 || bus.FRAME_READY !== 1'b1 || bus.WORD_CNT !== 4'd4) begin
      errors++; $display("FAIL abort_refill got done=%b fr=%b cnt=%0d exp 1 1 4", bus.FRAME_DONE, bus.FRAME_READY, bus.WORD_CNT);
    end
  endtask

  task automatic test_simultaneous();
    cycle(1, 8'h55, 1, 1);
    checks++;
    if (bus.FRAME_READY !== 1'b0 || bus.WORD_CNT !== 4'd0 || bus.DIN_READY !== 1'b0 || bus.W_A !== 1'b0) begin
      errors++; $display("FAIL abort_release got fr=%b cnt=%0d rdy=%b wa=%b exp 0 0 0 0", bus.FRAME_READY, bus.WORD_CNT, bus.DIN_READY, bus.W_A);
    end
    cycle(0, 8'h00, 0, 0);
    checks++;
    if (bus.DIN_READY !== 1'b1) begin errors++; $display("FAIL abort_release_ready got %b exp 1", bus.DIN_READY); end
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h60 + i), 0, 0);
    cycle(1, 8'h63, 0, 1);
    checks++;
    if (bus.W_A !== 1'b1 || bus.ADDR_A !== 4'd12 || bus.DIN_A !== 8'h63 || bus.FRAME_READY !== 1'b0 || bus.WORD_CNT !== e_cnt) begin
      errors++; $display("FAIL release_in_fill got wa=%b %h@%h fr=%b cnt=%0d exp 1 63@c 0 %0d",
                         bus.W_A, bus.DIN_A, bus.ADDR_A, bus.FRAME_READY, bus.WORD_CNT, e_cnt);
    end
    cycle(0, 8'h00, 1, 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 40 && m_n < 9; i++) cycle(1, 8'($urandom), 0, 0);
    checks++;
    if (bus.WORD_CNT !== 4'd2) begin errors++; $display("FAIL mid_cnt got %0d exp 2", bus.WORD_CNT); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({bus.DIN_READY, bus.DIN_A, bus.ADDR_A, bus.W_A, bus.EN_A, bus.FRAME_READY,
         bus.FRAME_DONE, bus.WORD_CNT} !== 21'h0) begin
      errors++; $display("FAIL async_reset got %h exp 0", {bus.DIN_READY, bus.DIN_A, bus.ADDR_A,
               bus.W_A, bus.EN_A, bus.FRAME_READY, bus.FRAME_DONE, bus.WORD_CNT});
    end
    bus.DIN_VALID = 1;
    @(posedge clk); #1;
    checks++;
    if (bus.DIN_READY !== 1'b0 || bus.W_A !== 1'b0) begin
      errors++; $display("FAIL reset_hold got rdy=%b wa=%b exp 0 0", bus.DIN_READY, bus.W_A);
    end
    rst_n = 1;
    model_reset();
    cycle(1, 8'h77, 0, 0);
    checks++;
    if (bus.DIN_READY !== 1'b1 || bus.W_A !== 1'b0) begin
      errors++; $display("FAIL reset_idle got rdy=%b wa=%b exp 1 0", bus.DIN_READY, bus.W_A);
    end
    cycle(1, 8'h78, 0, 0);
    checks++;
    if (bus.W_A !== 1'b1 || bus.ADDR_A !== 4'd0 || bus.DIN_A !== 8'h78) begin
      errors++; $display("FAIL reset_first_write got wa=%b %h@%h exp 1 78@0", bus.W_A, bus.DIN_A, bus.ADDR_A);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_backpressure();
    test_gapped();
    test_abort();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_byte_packer.md
# bram_byte_packer

Write-side controller for the 18 Kb true-dual-port BRAM that accepts a byte stream on a valid/ready handshake and drives the BRAM write port (byte data, address, write strobe, enable). Byte k of word w is written to address `w + k*BASE_ADDRESS`. The read port returns the four quadrant bytes concatenated, so it sees `{byte3, byte2, byte1, byte0}` as one 32-bit word. The block fills one frame of `WORDS` 32-bit words, then holds the buffer until the downstream reader releases it.

## Interface

**Parameters**
- `BASE_ADDRESS`, default 512: quadrant stride in bytes; must equal the BRAM's quadrant stride.
- `ADDR_WIDTH`, default 11: BRAM port-A address width; `4*BASE_ADDRESS <= 2**ADDR_WIDTH`.
- `WORDS`, default 512: 32-bit words per frame; `1 <= WORDS <= BASE_ADDRESS`.

**Ports**
- `CLK` in 1: single clock; all logic is rising-edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `DIN` in 8: input byte.
- `DIN_VALID` in 1: `DIN` is valid.
- `DIN_READY` out 1: block can accept a byte; a byte transfers when `DIN_VALID && DIN_READY` at a rising edge.
- `ABORT` in 1: synchronous frame discard.
- `RELEASE` in 1: single-cycle pulse from the reader; the buffer is consumed.
- `DIN_A` out 8: BRAM write data.
- `ADDR_A` out `ADDR_WIDTH`: BRAM write address.
- `W_A` out 1: BRAM write strobe.
- `EN_A` out 1: BRAM port-A enable.
- `FRAME_READY` out 1: level; the buffer holds a complete frame.
- `FRAME_DONE` out 1: one-cycle pulse when the frame completes.
- `WORD_CNT` out `ADDR_WIDTH`: complete words accepted in the current frame.

## Operation
- **FSM states:** IDLE, FILL, FULL. Reset enters IDLE.
- **IDLE:** goes to FILL on the next clock unconditionally.
- **Counters:** `lane` is 2 bits; `word` runs 0..WORDS-1.
- **On each accepted byte:**
  - The registered write presents `DIN_A=DIN`, `ADDR_A=word + lane*BASE_ADDRESS`, `W_A=EN_A=1`.
  - `lane` increments.
  - On the lane 3→0 wrap, `word` and `WORD_CNT` increment.
- **Frame completion (FILL→FULL):** occurs on acceptance of the byte with `lane=3`, `word=WORDS-1`.
  - `FRAME_DONE` pulses and `FRAME_READY` is set, both registered.
  - `lane` and `word` clear to 0. `WORD_CNT` holds `WORDS`.
- **FULL:**
  - `DIN_READY=0`.
  - `RELEASE` moves to FILL, clears `FRAME_READY` and clears `WORD_CNT` to 0.
- **`RELEASE` in IDLE/FILL:** ignored.
- **`ABORT` (any state except IDLE):**
  - Clears `lane`, `word`, `WORD_CNT` and `FRAME_READY`, and enters FILL.
  - A byte presented in the same cycle is not accepted.
  - Bytes already written stay in the BRAM and are overwritten by the next frame.
- **`ABORT` vs `RELEASE`:** `ABORT` has priority; both in FULL give FILL with cleared state.
- **`DIN_READY`:** registered, equal to (next state == FILL) and not `ABORT`. It drops in the same edge that accepts the final byte, so no byte is accepted in FULL.
- **`ADDR_A` arithmetic:** computed at `ADDR_WIDTH` bits; with legal parameters it never wraps.

## Timing
- **Reset values:** `DIN_READY=0`, `DIN_A=0`, `ADDR_A=0`, `W_A=0`, `EN_A=0`, `FRAME_READY=0`, `FRAME_DONE=0`, `WORD_CNT=0`, state IDLE.
- **After reset release:**
  - Edge 1: IDLE→FILL and `DIN_READY` goes to 1.
  - Edge 2: earliest byte acceptance.
- **Write latency:** a byte accepted at edge n appears on `DIN_A/ADDR_A` with `W_A=EN_A=1` after edge n, for exactly one cycle. With no acceptance at an edge, `W_A=EN_A=0`; `DIN_A` and `ADDR_A` hold.
- **Throughput:** 1 byte per cycle; a frame takes 4*WORDS accepting cycles.
- **Frame completion:** `FRAME_DONE` and `FRAME_READY` rise after the same edge that registers the last write. The BRAM write completes at the following edge, and the reader must not read before that edge.
- **`RELEASE` at edge n:** `DIN_READY=1` after edge n and a byte is accepted at edge n+1.
- **Reset mid-frame:** all outputs return immediately to their reset values; any partial frame is discarded.

## Test plan
- **Small-config fill** (`BASE_ADDRESS=4`, `ADDR_WIDTH=4`, `WORDS=4`): stream bytes 0x10..0x1F with continuous valid.
  - Writes go to addresses 0,4,8,12,1,5,9,13,…,15.
  - `FRAME_DONE` pulses once; `FRAME_READY=1`; `WORD_CNT=4`.
  - BRAM read addr 0 = 0x13121110; read addr 3 = 0x1F1E1D1C.
- **Backpressure:** keep `DIN_VALID` high after the 16th byte.
  - `DIN_READY=0` and no `W_A` while FULL.
  - `RELEASE` pulse gives `DIN_READY=1` next cycle; the next byte goes to address 0; `WORD_CNT=0`.
- **Gapped valid:** randomly deassert `DIN_VALID`. Addresses and data are identical to the fill test; `W_A` toggles only on accepted bytes.
- **Abort:** `ABORT` after 6 bytes.
  - `WORD_CNT` returns to 0; the next byte is written to addr 0.
  - A full frame afterwards completes normally.
- **Simultaneous events:**
  - `ABORT` and `RELEASE` together in FULL leaves FILL with `FRAME_READY=0`.
  - `RELEASE` during FILL is ignored.
- **Async reset mid-frame:** reset after 9 bytes; all outputs are at reset values while `RST_N=0`. After release the first write goes to addr 0.
